ans_accumulator: RTL

- Downstream consumer of the 2-bit adder result `ans`.
- Collects BURST_LEN result beats over a valid/ready handshake and sums them into an ACC_W-bit accumulator.
- Presents the burst total on a registered output handshake.
- Sits between the adder and any checker or reporting logic, turning a per-operation result stream into per-burst totals.

---
 rtl/ans_acc_pkg.sv | 28 ++
 rtl/ans_accumulator.sv | 114 +++++++++++
 2 files changed

// File: rtl/ans_acc_pkg.sv
// Shared types and helpers for the ans result accumulator.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package ans_acc_pkg;

    localparam int ANS_W = 2;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } ans_acc_state_t;

    // Saturating add of an ANS_W-bit beat onto a w-bit accumulator (w <= 32).
    // Result is clamped to 2^w-1; caller truncates to its own width.
    function automatic logic [31:0] sat_add(input logic [31:0]      acc,
                                            input logic [ANS_W-1:0] val,
                                            input int unsigned      w);
        logic [32:0] sum;
        logic [32:0] maxv;
        sum  = {1'b0, acc} + {31'b0, val};
        maxv = (33'd1 << w) - 33'd1;
        if (sum > maxv) begin
            return maxv[31:0];
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/ans_accumulator.sv
// Sums BURST_LEN ans beats into an ACC_W-bit total and presents it as one registered result.
// Latency: out_valid rises the cycle after the final beat of a burst transfers.
// Backpressure: in_ready drops while a result waits; ANS_ACC_SAT_EN selects saturation instead of wrap.
module ans_accumulator
    import ans_acc_pkg::*;
#(
    parameter int ACC_W     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ANS_W-1:0] in_ans,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_overflow
);

    localparam int            CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    ans_acc_state_t   r_state;
    ans_acc_state_t   w_next_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [ACC_W-1:0] r_out_sum;
    logic             r_out_ovf;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_beat;
    logic             w_result;
    logic             w_last;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_carry;

`ifdef ANS_ACC_SAT_EN
    // Clamp at all-ones; a carry out of ACC_W bits still marks overflow.
    assign w_acc_nxt = ACC_W'(sat_add(32'(r_acc), in_ans, ACC_W));
    assign w_carry   = ({1'b0, r_acc} + (ACC_W+1)'(in_ans)) > {1'b0, {ACC_W{1'b1}}};
`else
    logic [ACC_W:0] w_sum;
    assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(in_ans);
    assign w_acc_nxt = w_sum[ACC_W-1:0];
    assign w_carry   = w_sum[ACC_W];
`endif

    assign w_beat   = in_valid && w_in_ready;
    assign w_result = w_out_valid && out_ready;
    assign w_last   = (r_cnt == LAST_BEAT);

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_sum      = r_out_sum;
    assign out_overflow = r_out_ovf;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and handshake outputs; in_ready is held low while reset is asserted.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ACCUM: begin
                w_in_ready = ~rst;
                if (in_valid && w_in_ready && w_last) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ACCUM;
                end
            end
            default: w_next_state = ACCUM;
        endcase
    end

    // Accumulate beats, capture the total on the last beat, clear once it is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_sum <= '0;
            r_out_ovf <= 1'b0;
        end else if (w_result) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_beat) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            r_ovf <= r_ovf | w_carry;
            if (w_last) begin
                r_out_sum <= w_acc_nxt;
                r_out_ovf <= r_ovf | w_carry;
            end
        end
    end

endmodule
